pio_pulse_train: RTL

//  Consumes the 32-bit command word driven by the Avalon PIO output register and

---
 rtl/pio_pulse_pkg.sv | 30 +++
 rtl/pio_pulse_timer.sv | 28 ++
 rtl/pio_pulse_train.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pio_pulse_pkg.sv
// Shared constants for the PIO-driven pulse train: command word field
// positions, op codes and the phase state encoding.
package pio_pulse_pkg;

  localparam int TOG_BIT = 31;
  localparam int OP_HI   = 30;
  localparam int OP_LO   = 29;
  localparam int N_HI    = 28;
  localparam int N_LO    = 16;
  localparam int P_HI    = 15;
  localparam int P_LO    = 0;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_ABORT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Effective period: never shorter than the high time plus one low cycle.
  function automatic logic [15:0] peff_clamp(input logic [15:0] p, input int pulse_w);
    logic [15:0] floor_p;
    floor_p = 16'(pulse_w + 1);
    return (p < floor_p) ? floor_p : p;
  endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// Loadable 16-bit down-counter; stops at zero and flags it. Used to time
// both the high and the low phase of each pulse.
module pio_pulse_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        zero_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (count_q != 16'd0)
      count_d = count_q - 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= 16'd0;
    else          count_q <= count_d;
  end

  assign zero_o = (count_q == 16'd0);

endmodule

// File: rtl/pio_pulse_train.sv
// Pulse train generator driven by a PIO command word; a command fires on
// every flip of the toggle bit. status mirrors progress for CPU polling.
module pio_pulse_train
  import pio_pulse_pkg::*;
#(
  parameter int PULSE_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  output logic        pulse_out,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [12:0] pulse_cnt,
  output logic [31:0] status,
  output logic [1:0]  state_dbg
);

  state_e      state_q, state_d;
  logic        tog_q, tog_d;
  logic        pulse_q, pulse_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic [12:0] cnt_q, cnt_d;
  logic [12:0] n_q, n_d;
  logic [15:0] peff_q, peff_d;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_zero;
  logic [1:0]  op;

  assign op = cmd_word[OP_HI:OP_LO];

  pio_pulse_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    tog_d     = tog_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    peff_d    = peff_q;
    tmr_load  = 1'b0;
    tmr_val   = 16'd0;

    case (state_q)
      HIGH: if (tmr_zero) begin
        state_d  = LOW;
        pulse_d  = 1'b0;
        cnt_d    = cnt_q + 13'd1;
        tmr_load = 1'b1;
        tmr_val  = peff_q - 16'(PULSE_W) - 16'd1;
      end
      LOW: if (tmr_zero) begin
        if (cnt_q < n_q) begin
          state_d  = HIGH;
          pulse_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = 16'(PULSE_W - 1);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    // An accepted START/ABORT overrides whatever the phase logic decided above.
    if (cmd_word[TOG_BIT] != tog_q) begin
      tog_d = cmd_word[TOG_BIT];
      case (op)
        OP_START: begin
          n_d       = cmd_word[N_HI:N_LO];
          peff_d    = peff_clamp(cmd_word[P_HI:P_LO], PULSE_W);
          cnt_d     = 13'd0;
          aborted_d = 1'b0;
          if (cmd_word[N_HI:N_LO] == 13'd0) begin
            state_d = IDLE;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = HIGH;
            pulse_d  = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = 16'(PULSE_W - 1);
          end
        end
        OP_ABORT: begin
          done_d = 1'b0;
          if (busy_q) begin
            state_d   = IDLE;
            pulse_d   = 1'b0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tog_q     <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cnt_q     <= 13'd0;
      n_q       <= 13'd0;
      peff_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      tog_q     <= tog_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      peff_q    <= peff_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign pulse_cnt = cnt_q;
  assign status    = {busy_q, done_q, aborted_q, cnt_q, 16'h0000};
  assign state_dbg = state_q;

endmodule
